decode_ctrl_stage: RTL

- Registered RV32I decode/control stage; successor to the combinational control-signal decoder.
- Decodes every base opcode class (R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC), not only R/I/store.
- Produces the full control bundle: ALU op, immediate, writeback select, memory controls and an illegal flag.
- Holds the bundle in an ID/EX register with valid/ready handshake and flush. Sits between fetch and execute.

---
 rtl/decode_ctrl_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage with an ID/EX valid/ready register and flush.
// Optional load-use interlock is compiled in with `define LOAD_USE_STALL_EN.
module decode_ctrl_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_imm,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_reg_write,
    output logic                out_op_b,
    output logic [1:0]          out_rd_sel,
    output logic [2:0]          out_imm_sel,
    output logic                out_func7_sel,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic                out_branch,
    output logic                out_jump,
    output logic                out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] aluOp;
        logic                regWrite;
        logic                opB;
        logic [1:0]          rdSel;
        logic [2:0]          immSel;
        logic                func7Sel;
        logic                memRead;
        logic                memWrite;
        logic                branch;
        logic                jump;
        logic                illegal;
    } bundle_t;

    bundle_t bundle_d, bundle_q;
    logic    valid_d, valid_q;
    logic    accept;
    logic    hazard;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] imm32;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Shared funct3 mapping for R-type and I-ALU; alt selects SUB/SRA.
    function automatic logic [ALU_OP_W-1:0] aluFromFunct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    aluFromFunct3 = alt ? ALU_SUB : ALU_ADD;
            3'd1:    aluFromFunct3 = ALU_SLL;
            3'd2:    aluFromFunct3 = ALU_SLT;
            3'd3:    aluFromFunct3 = ALU_SLTU;
            3'd4:    aluFromFunct3 = ALU_XOR;
            3'd5:    aluFromFunct3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    aluFromFunct3 = ALU_OR;
            default: aluFromFunct3 = ALU_AND;
        endcase
    endfunction

    always_comb begin
        bundle_d     = '0;
        imm32        = '0;
        bundle_d.pc  = in_pc;
        bundle_d.rs1 = in_instr[19:15];
        bundle_d.rs2 = in_instr[24:20];
        bundle_d.rd  = in_instr[11:7];
        case (opcode)
            OP_R: begin
                bundle_d.aluOp    = aluFromFunct3(funct3, in_instr[30]);
                bundle_d.regWrite = 1'b1;
                bundle_d.func7Sel = 1'b1;
            end
            OP_I: begin
                imm32             = {{20{in_instr[31]}}, in_instr[31:20]};
                bundle_d.aluOp    = aluFromFunct3(funct3, (funct3 == 3'd5) && in_instr[30]);
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.func7Sel = (funct3 == 3'd5);
            end
            OP_LOAD: begin
                imm32             = {{20{in_instr[31]}}, in_instr[31:20]};
                bundle_d.aluOp    = ALU_ADD;
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.rdSel    = 2'd1;
                bundle_d.memRead  = 1'b1;
            end
            OP_STORE: begin
                imm32             = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                bundle_d.aluOp    = ALU_ADD;
                bundle_d.opB      = 1'b1;
                bundle_d.immSel   = 3'd1;
                bundle_d.memWrite = 1'b1;
            end
            OP_BRANCH: begin
                imm32             = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                     in_instr[30:25], in_instr[11:8], 1'b0};
                bundle_d.aluOp    = ALU_SUB;
                bundle_d.immSel   = 3'd2;
                bundle_d.branch   = 1'b1;
            end
            OP_JAL: begin
                imm32             = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                     in_instr[20], in_instr[30:21], 1'b0};
                bundle_d.aluOp    = ALU_ADD;
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.rdSel    = 2'd2;
                bundle_d.immSel   = 3'd4;
                bundle_d.jump     = 1'b1;
            end
            OP_JALR: begin
                imm32             = {{20{in_instr[31]}}, in_instr[31:20]};
                bundle_d.aluOp    = ALU_ADD;
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.rdSel    = 2'd2;
                bundle_d.jump     = 1'b1;
            end
            OP_LUI: begin
                imm32             = {in_instr[31:12], 12'b0};
                bundle_d.aluOp    = ALU_PASSB;
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.immSel   = 3'd3;
            end
            OP_AUIPC: begin
                imm32             = {in_instr[31:12], 12'b0};
                bundle_d.aluOp    = ALU_ADD;
                bundle_d.regWrite = 1'b1;
                bundle_d.opB      = 1'b1;
                bundle_d.immSel   = 3'd3;
            end
            default: begin
                bundle_d.illegal  = 1'b1;
            end
        endcase
        bundle_d.imm = XLEN'(imm32);
    end

`ifdef LOAD_USE_STALL_EN
    // A load in the output register whose rd feeds the incoming instruction must drain first.
    logic usesRs2;
    assign usesRs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign hazard  = valid_q && bundle_q.memRead && (bundle_q.rd != 5'd0) &&
                     ((in_instr[19:15] == bundle_q.rd) ||
                      (usesRs2 && (in_instr[24:20] == bundle_q.rd)));
`else
    assign hazard  = 1'b0;
`endif

    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
    end

    // Payload loads on every accept, even a flushed one; only valid is killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept)
                bundle_q <= bundle_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_rs1       = bundle_q.rs1;
    assign out_rs2       = bundle_q.rs2;
    assign out_rd        = bundle_q.rd;
    assign out_imm       = bundle_q.imm;
    assign out_alu_op    = bundle_q.aluOp;
    assign out_reg_write = bundle_q.regWrite;
    assign out_op_b      = bundle_q.opB;
    assign out_rd_sel    = bundle_q.rdSel;
    assign out_imm_sel   = bundle_q.immSel;
    assign out_func7_sel = bundle_q.func7Sel;
    assign out_mem_read  = bundle_q.memRead;
    assign out_mem_write = bundle_q.memWrite;
    assign out_branch    = bundle_q.branch;
    assign out_jump      = bundle_q.jump;
    assign out_illegal   = bundle_q.illegal;

endmodule
